// File: rtl/data_mem_ctrl.sv
// Data memory for the MEM stage: byte-addressable RAM organised as XLEN/8-byte
// words with per-byte write enables, sized loads/stores with sign or zero
// extension, a configurable access latency exposed through v_mem_stall, and
// detection of misaligned accesses (flagged instead of touching memory).
module data_mem_ctrl #(
    parameter int XLEN      = 64,
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            MEM_V,
    input  logic            we,
    input  logic [1:0]      size,
    input  logic            load_unsigned,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] address,
    output logic            v_mem_stall,
    output logic [XLEN-1:0] data_out,
    output logic            misaligned
);

    localparam int BYTES    = XLEN / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int WORDS    = 2 ** (ADDR_BITS - OFF_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [XLEN-1:0]         wdata_q;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [XLEN-1:0]         data_out_q;
    logic                    misaligned_q;

    // Zero-initialised at time 0 only; never cleared by reset.
    logic [XLEN-1:0]         mem_q [WORDS] = '{default: '0};

    logic                    req_misaligned;
    logic                    access;
    logic [OFF_BITS-1:0]     offset;
    logic [ADDR_BITS-OFF_BITS-1:0] word_idx;
    logic [BYTES-1:0]        lane_mask;
    logic [BYTES-1:0]        byte_en;
    logic [XLEN-1:0]         shifted_wdata;
    logic [XLEN-1:0]         field;
    logic [XLEN-1:0]         load_ext;

    // Upper address bits wrap by design; they are intentionally ignored.
    logic                    unused_addr;
    assign unused_addr = ^address[XLEN-1:ADDR_BITS];

    // Alignment check of the incoming request against its natural size.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        req_misaligned = 1'b0;
        case (size)
            2'b01:   req_misaligned = address[0];
            2'b10:   req_misaligned = |address[1:0];
            2'b11:   req_misaligned = |address[2:0];
            default: req_misaligned = 1'b0;
        endcase
    end

    assign access   = (state_q == WAIT) && MEM_V && (cnt_q == 4'd0);
    assign offset   = addr_q[OFF_BITS-1:0];
    assign word_idx = addr_q[ADDR_BITS-1:OFF_BITS];

    // Byte lanes touched by the latched access and store data moved onto them.
    always_comb begin
        lane_mask     = BYTES'((32'd1 << (32'd1 << size_q)) - 32'd1);
        byte_en       = lane_mask << offset;
        shifted_wdata = wdata_q << {offset, 3'b000};
    end

    // Select the addressed field from the word and extend it to XLEN.
    always_comb begin
        field    = mem_q[word_idx] >> {offset, 3'b000};
        load_ext = field;
        case (size_q)
            2'b00: load_ext = uns_q ? XLEN'(field[7:0])
                                    : {{(XLEN-8){field[7]}}, field[7:0]};
            2'b01: load_ext = uns_q ? XLEN'(field[15:0])
                                    : {{(XLEN-16){field[15]}}, field[15:0]};
            2'b10: load_ext = uns_q ? XLEN'(field[31:0])
                                    : {{(XLEN-32){field[31]}}, field[31:0]};
            default: load_ext = field;
        endcase
    end

    // Access FSM: request capture, latency countdown, one-cycle completion.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            addr_q       <= '0;
            data_out_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MEM_V) begin
                        if (req_misaligned) begin
                            state_q      <= DONE;
                            misaligned_q <= 1'b1;
                            data_out_q   <= '0;
                        end else begin
                            we_q    <= we;
                            size_q  <= size;
                            uns_q   <= load_unsigned;
                            wdata_q <= mem_data;
                            addr_q  <= address[ADDR_BITS-1:0];
                            cnt_q   <= 4'(LATENCY - 1);
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!MEM_V) begin
                        state_q <= IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        data_out_q <= we_q ? '0 : load_ext;
                        state_q    <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM write port: only the WAIT->DONE edge of a store commits bytes.
    always_ff @(posedge CLK) begin
        // NOTE: the RAM array has no reset so it maps onto block memory; reset drops a pending store by forcing the FSM out of WAIT.
        if (access && we_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= shifted_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign v_mem_stall = MEM_V & (state_q != DONE);
    assign data_out    = data_out_q;
    assign misaligned  = misaligned_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised data memory for the MEM stage; generalises the single-word, fixed-latency data memory.
- Holds 2^ADDR_BITS bytes as XLEN/8-byte words with per-byte write enables.
- Supports byte/half/word/double loads and stores at any naturally aligned offset, with sign or zero extension on loads.
- Models a configurable access latency through the existing v_mem_stall handshake and flags misaligned accesses instead of silently corrupting memory.

Parameters:
- XLEN, 64: data path width in bits; fixed at 64 this generation, and size=2'b11 is a doubleword.
- ADDR_BITS, 12: log2 of memory size in bytes; minimum 4.
- LATENCY, 1: number of WAIT cycles per access; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MEM_V  in  1  valid memory op present in MEM stage; held until v_mem_stall is low.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 double.
- load_unsigned  in  1  1 = zero-extend load result, 0 = sign-extend.
- mem_data  in  XLEN  store data; the low 8<<size bits are used.
- address  in  XLEN  byte address; only bits [ADDR_BITS-1:0] are used, and the upper bits wrap.
- v_mem_stall  out  1  1 = hold the pipeline; the access is not complete.
- data_out  out  XLEN  extended load result; valid in the DONE cycle only.
- misaligned  out  1  1 in the DONE cycle of a misaligned access.

Behaviour:
- Misalignment rules:
  - size 01 requires address[0]=0.
  - size 10 requires address[1:0]=0.
  - size 11 requires address[2:0]=0.
  - size 00 is never misaligned.
- FSM states: IDLE, WAIT, DONE. The counter cnt is 4 bits wide.
- IDLE:
  - MEM_V=1 and aligned: latch we, size, load_unsigned, mem_data and address[ADDR_BITS-1:0]; cnt <= LATENCY-1; go to WAIT.
  - MEM_V=1 and misaligned: go directly to DONE with the misaligned flag set; no memory access.
  - MEM_V=0: stay in IDLE.
- WAIT:
  - MEM_V=0: abort (pipeline flush). Go to IDLE with no write and no output change.
  - cnt!=0: cnt <= cnt-1.
  - cnt==0: perform the access on this edge.
    - Store: write the enabled bytes of word address[ADDR_BITS-1:3] at byte lanes address[2:0] up to address[2:0]+(1<<size)-1, taking them from the low bytes of mem_data.
    - Load: register the extended result into data_out.
    - Then go to DONE.
- DONE:
  - Lasts exactly one cycle; next state is IDLE regardless of MEM_V.
  - A new request is accepted only from IDLE, so back-to-back requests cost one idle edge.
- v_mem_stall = MEM_V & (state != DONE); combinational.
  - An aligned access stalls for LATENCY+1 cycles and completes in the DONE cycle.
  - A misaligned access stalls for exactly 1 cycle.
- data_out:
  - Registered.
  - Cleared to 0 on entering DONE for stores and misaligned accesses.
  - Holds its value in all other states.
  - Load extension from the top bit of the selected field: bit 7, 15 or 31, or none for a double.
- misaligned: registered; 1 only in the DONE cycle of a misaligned access, 0 otherwise.
- Read and write in the same access are impossible; a load in the cycle after a store to the same bytes returns the new data.
- Reset (asynchronous, any state, including mid-WAIT):
  - State -> IDLE, cnt -> 0, data_out -> 0, misaligned -> 0, v_mem_stall follows the combinational rule.
  - A pending store is dropped.
  - Memory contents are not reset (inferred RAM). Contents are zero-initialised at time 0 only.
- The memory array is written only at the WAIT->DONE edge; no other path writes it.

Test Plan:
1. LATENCY=1. Store size=11, addr 0x10, data 0x8877665544332211; then load size=11 from 0x10 -> v_mem_stall high for 2 cycles; data_out=0x8877665544332211 in DONE.
2. Store byte 0xF0 at 0x13; load size=00, unsigned=0 from 0x13 -> 0xFFFFFFFFFFFFFFF0. With unsigned=1 -> 0x00000000000000F0. Byte 0x12 is still 0x33.
3. Half store 0x8001 at 0x16; load half signed -> 0xFFFFFFFFFFFF8001. Word load unsigned from 0x14 -> 0x0000000080016655.
4. Word load at 0x22 -> misaligned=1 for one cycle; stall for 1 cycle; data_out=0; memory unchanged. Half at 0x21 behaves the same. A byte at 0x21 is not misaligned.
5. LATENCY=4. Store issued, MEM_V dropped during the 2nd WAIT cycle -> FSM returns to IDLE; a subsequent load shows the old data. An uninterrupted access stalls 5 cycles.
6. Assert reset mid-WAIT of a store -> outputs 0 immediately, store not committed. Address 0x1010 with ADDR_BITS=12 aliases to 0x010.
